// File: rtl/store_rmw_ctrl.sv
// Store read-modify-write sequencer. Byte and halfword stores read the addressed word,
// merge the low bits of B into it, and write it back. Word stores skip the read.
module store_rmw_ctrl #(
  parameter int READ_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_store_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_b_out,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(READ_LAT - 1);

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_b, r_data;
  logic [1:0]  r_size;
  logic [3:0]  r_cnt;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && i_start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          case (i_store_size)
            2'b00:   w_next = WRITE;
            2'b11:   w_next = ERR;
            default: w_next = READ;
          endcase
        end
      end
      READ:    if (r_cnt == 4'd0) w_next = CAPTURE;
      CAPTURE: w_next = WRITE;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_b     <= '0;
      r_size  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= i_addr;
        r_b    <= i_b_out;
        r_size <= i_store_size;
        r_cnt  <= LP_CNT_LOAD;
      end else if (r_state == READ && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == CAPTURE) r_data <= i_mem_rdata;
    end
  end

  // Outputs decode straight from state so reset clears them asynchronously.
  assign o_busy     = (r_state != IDLE);
  assign o_mem_addr = (r_state != IDLE) ? r_addr : 32'd0;
  assign o_mem_wr   = (r_state == WRITE);
  assign o_done     = (r_state == DONE) || (r_state == ERR);
  assign o_err      = (r_state == ERR);

  always_comb begin
    o_mem_wdata = r_b;
    case (r_size)
      2'b01:   o_mem_wdata = {r_data[31:8],  r_b[7:0]};
      2'b10:   o_mem_wdata = {r_data[31:16], r_b[15:0]};
      default: o_mem_wdata = r_b;
    endcase
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Scoreboard bench for store_rmw_ctrl. Two instances cover READ_LAT=1 and READ_LAT=3.
// Each instance has its own backing memory model with the matching read latency.
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3;
  logic [1:0]  size;
  logic [31:0] addr, b;
  logic [31:0] rdata1, rdata3;
  logic [31:0] maddr1, maddr3, wdata1, wdata3;
  logic        wr1, wr3, busy1, busy3, done1, done3, err1, err3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit          is_wr;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
  } ev_t;

  ev_t q1[$];
  ev_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_rmw_ctrl #(.READ_LAT(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start1), .i_store_size(size),
    .i_addr(addr), .i_b_out(b), .i_mem_rdata(rdata1),
    .o_mem_addr(maddr1), .o_mem_wr(wr1), .o_mem_wdata(wdata1),
    .o_busy(busy1), .o_done(done1), .o_err(err1)
  );

  store_rmw_ctrl #(.READ_LAT(3)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start3), .i_store_size(size),
    .i_addr(addr), .i_b_out(b), .i_mem_rdata(rdata3),
    .o_mem_addr(maddr3), .o_mem_wr(wr3), .o_mem_wdata(wdata3),
    .o_busy(busy3), .o_done(done3), .o_err(err3)
  );

  function automatic logic [31:0] memrd(input logic [31:0] a);
    case (a)
      32'h80, 32'h84: memrd = 32'h11223344;
      default:        memrd = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Read pipelines: data for the address of cycle n appears in cycle n+READ_LAT.
  logic [31:0] rp1;
  logic [31:0] rp3 [3];
  always @(posedge clk) begin
    rp1    <= memrd(maddr1);
    rp3[0] <= memrd(maddr3);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign rdata1 = rp1;
  assign rdata3 = rp3[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic wr, input logic dn, input logic er,
                     input logic bz, input logic [31:0] a, input logic [31:0] wd);
    ev_t e;
    if (!(wr || dn || er)) return;
    if (er && !dn) chk($sformatf("dut%0d err_without_done", d), 32'(er), 32'd0);
    if ((d == 1) ? (q1.size() == 0) : (q3.size() == 0)) begin
      chk($sformatf("dut%0d unexpected_output wr/done", d), {30'd0, wr, dn}, 32'd0);
      return;
    end
    e = (d == 1) ? q1.pop_front() : q3.pop_front();
    chk($sformatf("dut%0d event_kind_is_wr", d), 32'(wr), 32'(e.is_wr));
    chk($sformatf("dut%0d event_cycle", d), 32'(cyc), 32'(e.cyc));
    if (e.is_wr) begin
      chk($sformatf("dut%0d mem_addr", d), a, e.addr);
      chk($sformatf("dut%0d mem_wdata", d), wd, e.wdata);
      chk($sformatf("dut%0d busy_in_write", d), 32'(bz), 32'd1);
    end else begin
      chk($sformatf("dut%0d done", d), 32'(dn), 32'd1);
      chk($sformatf("dut%0d err", d), 32'(er), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    mon(1, wr1, done1, err1, busy1, maddr1, wdata1);
    mon(3, wr3, done3, err3, busy3, maddr3, wdata3);
  end

  task automatic push(input int d, input bit is_wr, input int c,
                      input logic [31:0] a, input logic [31:0] wd, input bit er);
    ev_t e;
    e.is_wr = is_wr; e.cyc = c; e.addr = a; e.wdata = wd; e.err = er;
    if (d == 1) q1.push_back(e); else q3.push_back(e);
  endtask

  // Drives start for one cycle at a negedge; returns cycle 0 of the operation.
  task automatic issue(input int d, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] bv, output int k);
    size = s; addr = a; b = bv;
    if (d == 1) start1 = 1'b1; else start3 = 1'b1;
    k = cyc;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    chk({name, " q1_empty"}, 32'(q1.size()), 32'd0);
    chk({name, " q3_empty"}, 32'(q3.size()), 32'd0);
    q1.delete(); q3.delete();
  endtask

  initial begin
    int k;
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    size = 2'b00; addr = '0; b = '0;
    #1;
    chk("reset mem_addr1", maddr1, 32'd0);
    chk("reset mem_wdata1", wdata1, 32'd0);
    chk("reset ctl1 wr/busy/done/err", {28'd0, wr1, busy1, done1, err1}, 32'd0);
    chk("reset ctl3 wr/busy/done/err", {28'd0, wr3, busy3, done3, err3}, 32'd0);
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle wr/busy", {28'd0, wr1, busy1, wr3, busy3}, 32'd0);
    end

    // Word store
    push(1, 1, cyc + 1, 32'h40, 32'hDEADBEEF, 0);
    push(1, 0, cyc + 2, 0, 0, 0);
    issue(1, 2'b00, 32'h40, 32'hDEADBEEF, k);
    idle(4); drain("word");

    // Byte store, READ_LAT=1
    push(1, 1, cyc + 3, 32'h80, 32'h112233DD, 0);
    push(1, 0, cyc + 4, 0, 0, 0);
    issue(1, 2'b01, 32'h80, 32'hAABBCCDD, k);
    idle(5); drain("byte lat1");

    // Byte store, READ_LAT=3
    push(3, 1, cyc + 5, 32'h80, 32'h112233DD, 0);
    push(3, 0, cyc + 6, 0, 0, 0);
    issue(3, 2'b01, 32'h80, 32'hAABBCCDD, k);
    idle(7); drain("byte lat3");

    // Halfword store, b_out and other inputs change in cycle 2
    push(1, 1, cyc + 3, 32'h84, 32'h1122BEEF, 0);
    push(1, 0, cyc + 4, 0, 0, 0);
    issue(1, 2'b10, 32'h84, 32'h0000BEEF, k);
    @(negedge clk);
    b = 32'h0; addr = 32'h200; size = 2'b00;
    idle(4); drain("half");

    // Illegal size
    push(1, 0, cyc + 1, 0, 0, 1);
    issue(1, 2'b11, 32'h40, 32'h1, k);
    idle(3); drain("illegal");

    // start held while busy must not launch a second store
    push(3, 1, cyc + 5, 32'h80, 32'h112233DD, 0);
    push(3, 0, cyc + 6, 0, 0, 0);
    size = 2'b01; addr = 32'h80; b = 32'hAABBCCDD;
    start3 = 1'b1;
    idle(4);
    addr = 32'h300; size = 2'b00;
    start3 = 1'b0;
    idle(6); drain("busy start");

    // Reset in CAPTURE of a byte store: no write should ever appear
    issue(1, 2'b01, 32'h80, 32'h55, k);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset busy/wr", {30'd0, busy1, wr1}, 32'd0);
    chk("midreset mem_addr", maddr1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(5); drain("midreset");

    // Word store after reset completes normally
    push(1, 1, cyc + 1, 32'h100, 32'h12345678, 0);
    push(1, 0, cyc + 2, 0, 0, 0);
    issue(1, 2'b00, 32'h100, 32'h12345678, k);
    idle(4); drain("post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
